fifo_tx: RTL and testbench
==========================

Name: fifo_tx

Overview:
Transmit-side buffer of the Zigbee datapath. The APB host writes WIDTH-bit words into a DEPTH-entry FIFO. A serializer pops the words and shifts them out LSB-first, one bit per bit_tick strobe from the modulator. The bit order mirrors the receive FIFO's serial-in order, so a looped-back stream reassembles identically.

Parameters:
WIDTH, 8, word width in bits (also the number of bits serialized per word)
DEPTH, 64, FIFO entries; must be a power of 2
PTR_WIDTH, $clog2(DEPTH), derived; pointers are PTR_WIDTH+1 bits (the MSB is the wrap bit)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB direction, 1 = write
pwdata  input  WIDTH  APB write data
pready  output  1  tied to 1 (no wait states)
pslverr  output  1  APB error (combinational)
tx_en  input  1  serializer enable
bit_tick  input  1  one-cycle strobe; advance to the next bit
data_out  output  1  serial data, LSB first
tx_busy  output  1  serializer holds a word
byte_done  output  1  one-cycle pulse on the tick that consumes the last bit of a word
full  output  1  FIFO full
empty  output  1  FIFO empty
fill_level  output  PTR_WIDTH+1  number of stored words, 0..DEPTH

Behaviour:
- Reset (asynchronous, reset_n=0):
  - wr_ptr, rd_ptr, shift register and bit_cnt cleared; state IDLE.
  - Outputs: data_out=0, tx_busy=0, byte_done=0, empty=1, full=0, fill_level=0.
  - Memory contents need not be cleared.
  - Reset mid-word aborts the word; no partial bits are resumed.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = lower PTR_WIDTH bits equal AND wrap bits differ.
  - fill_level = wr_ptr - rd_ptr, modulo 2^(PTR_WIDTH+1).
  - All three are combinational from the registered pointers.
- APB write:
  - An access is psel & penable. A write access is an access with pwrite=1.
  - If !full: mem[wr_ptr[PTR_WIDTH-1:0]] <= pwdata and wr_ptr++ at the clock edge.
  - If full: the write is dropped and pslverr=1 for that cycle.
  - Full is evaluated before any same-cycle pop, so a write to a full FIFO is rejected even if a pop happens in the same cycle.
- APB read access (pwrite=0): pslverr=1, no state change; the block has no read data.
- pslverr = psel & penable & (!pwrite | full); 0 otherwise.
- Serializer FSM, 2 states:
  - IDLE:
    - tx_busy=0, data_out=0.
    - If tx_en & !empty: pop (shreg <= mem[rd_ptr], rd_ptr++), bit_cnt <= 0, go to SHIFT.
    - data_out carries bit0 on the cycle after the pop.
  - SHIFT:
    - tx_busy=1, data_out = shreg[0] (registered).
    - On bit_tick with bit_cnt < WIDTH-1: shreg >>= 1, bit_cnt++.
    - On bit_tick with bit_cnt == WIDTH-1: byte_done=1 for that cycle, then:
      - if tx_en & !empty: pop the next word in the same cycle and stay in SHIFT. This gives a back-to-back stream with no gap ticks.
      - otherwise: go to IDLE.
    - bit_tick is ignored in IDLE.
- tx_en deasserted mid-word: the current word completes, then the FSM goes to IDLE. Output stalls indefinitely without bit_tick.
- Simultaneous APB write and pop: both occur; fill_level is unchanged.
  - Write into an empty FIFO: the data is visible to the FSM the next cycle (one cycle write-to-pop latency).
- Pointers wrap naturally at 2*DEPTH; the wrap bit disambiguates full from empty.

Test Plan:
1. Reset, then write 0xA5 with tx_en=1 and bit_tick every 4 clk → data_out sequence 1,0,1,0,0,1,0,1; byte_done pulses once on the 8th tick; tx_busy falls; empty=1.
2. Write 0x01, 0x80, 0xFF back-to-back, tx_en=1, bit_tick every cycle → 24 contiguous bits with no idle cycle; byte_done pulses at ticks 8, 16 and 24.
3. With tx_en=0, write 64 words 0..63 → full=1, fill_level=64. A 65th write of 0xEE gives pslverr=1 and is dropped. Enabling tx then yields words 0..63 in order.
4. With the FIFO full, write and pop in the same cycle → write rejected with pslverr=1; fill_level drops to 63.
5. APB read access (pwrite=0) → pslverr=1; pointers unchanged.
6. Assert reset_n=0 after 3 bits of 0x3C are sent → data_out=0, tx_busy=0, empty=1 immediately (asynchronous). After release, a new write of 0x55 serializes from bit0.

Source files
------------

// File: rtl/fifo_tx.sv
// fifo_tx: APB-written word FIFO feeding an LSB-first serializer.
// Ports: APB slave (psel/penable/pwrite/pwdata/pready/pslverr),
//   serial side (tx_en, bit_tick, data_out, tx_busy, byte_done),
//   status (full, empty, fill_level).
module fifo_tx #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [WIDTH-1:0]     pwdata,
    output logic                 pready,
    output logic                 pslverr,
    input  logic                 tx_en,
    input  logic                 bit_tick,
    output logic                 data_out,
    output logic                 tx_busy,
    output logic                 byte_done,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   fill_level
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [WIDTH-1:0]   shreg;
    logic [CW-1:0]      bit_cnt;
    state_t             state_q;
    state_t             state_d;

    logic access;
    logic do_write;
    logic pop;
    logic shift;

    assign empty = (wr_ptr == rd_ptr);
    // Equal index with differing wrap bit means the writer lapped the reader.
    assign full = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0])
               && (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
    assign fill_level = wr_ptr - rd_ptr;

    assign pready   = 1'b1;
    assign access   = psel & penable;
    // Full is taken before any same-cycle pop, so such a write is refused.
    assign do_write = access & pwrite & ~full;
    assign pslverr  = access & (~pwrite | full);

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        shift     = 1'b0;
        tx_busy   = 1'b0;
        data_out  = 1'b0;
        byte_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                tx_busy  = 1'b1;
                data_out = shreg[0];
                if (bit_tick) begin
                    if (bit_cnt == LAST) begin
                        byte_done = 1'b1;
                        // Reload on the final tick keeps the stream gapless.
                        if (tx_en && !empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                shreg   <= mem[rd_ptr[PTR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
                bit_cnt <= '0;
            end else if (shift) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= pwdata;
        end
    end

endmodule

// File: tb/tb_fifo_tx.sv
// tb_fifo_tx: scoreboard bench for fifo_tx.
// Stimulus pushes expected serial bits; a monitor pops them per bit tick.
module tb_fifo_tx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int PW    = $clog2(DEPTH);

    logic             clk = 0;
    logic             reset_n = 0;
    logic             psel = 0;
    logic             penable = 0;
    logic             pwrite = 0;
    logic [WIDTH-1:0] pwdata = '0;
    logic             pready;
    logic             pslverr;
    logic             tx_en = 0;
    logic             bit_tick = 0;
    logic             data_out;
    logic             tx_busy;
    logic             byte_done;
    logic             full;
    logic             empty;
    logic [PW:0]      fill_level;

    fifo_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .tx_en(tx_en), .bit_tick(bit_tick), .data_out(data_out),
        .tx_busy(tx_busy), .byte_done(byte_done),
        .full(full), .empty(empty), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Each entry: {last bit of word, bit value}
    logic [1:0] sb[$];
    int tick_per = 0;
    int bits_seen = 0;
    int bd_count = 0;
    int busy_run = 0;
    int last_run = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void push_word(logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++)
            sb.push_back({(i == WIDTH - 1), w[i]});
    endfunction

    // bit_tick generator: 0 = off, N>0 = every N cycles, <0 = random
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (tick_per > 0)
                bit_tick = (cnt % tick_per == 0);
            else if (tick_per < 0)
                bit_tick = ($urandom_range(2) == 0);
            else
                bit_tick = 0;
        end
    end

    // Monitor
    initial begin
        logic [1:0] e;
        logic       exp_bd;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                exp_bd = 0;
                if (tx_busy && bit_tick) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("data_out", data_out, e[0]);
                        exp_bd = e[1];
                        bits_seen++;
                    end
                end else if (!tx_busy) begin
                    chk("idle_data_out", data_out, 0);
                end
                chk("byte_done", byte_done, exp_bd);
                if (byte_done) bd_count++;
                if (tx_busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    last_run = busy_run;
                    busy_run = 0;
                end
            end
        end
    end

    task automatic apb_write(logic [WIDTH-1:0] d, logic exp_err);
        @(posedge clk);
        #1;
        psel = 1; penable = 1; pwrite = 1; pwdata = d;
        @(negedge clk);
        chk("pslverr_wr", pslverr, exp_err);
        chk("pready", pready, 1);
        if (!exp_err) push_word(d);
    endtask

    task automatic bus_idle();
        @(posedge clk);
        #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wait_drain(int bound);
        int n = 0;
        while (!(sb.size() == 0 && !tx_busy) && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", int'(n < bound), 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_data_out", data_out, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_byte_done", byte_done, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_pslverr", pslverr, 0);
        @(posedge clk);
        #1;
        reset_n = 1;

        // 1: single word, slow ticks
        tx_en = 1; tick_per = 4; bd_count = 0;
        apb_write(8'hA5, 0);
        bus_idle();
        wait_drain(200);
        chk("t1_bd_count", bd_count, 1);
        chk("t1_busy", tx_busy, 0);
        chk("t1_empty", empty, 1);

        // 2: back-to-back words, tick every cycle
        tick_per = 1; bd_count = 0; last_run = 0;
        apb_write(8'h01, 0);
        apb_write(8'h80, 0);
        apb_write(8'hFF, 0);
        bus_idle();
        wait_drain(200);
        repeat (2) @(negedge clk);
        chk("t2_bd_count", bd_count, 3);
        chk("t2_run_len", last_run, 3 * WIDTH);

        // 3: fill to full with serializer off
        tx_en = 0; tick_per = 0;
        for (int i = 0; i < DEPTH; i++) apb_write(WIDTH'(i), 0);
        bus_idle();
        #1;
        chk("t3_full", full, 1);
        chk("t3_fill", fill_level, DEPTH);
        apb_write(8'hEE, 1);
        bus_idle();
        #1;
        chk("t3_fill_after_drop", fill_level, DEPTH);

        // 4: write and pop in the same cycle while full
        @(posedge clk);
        #1;
        tx_en = 1;
        psel = 1; penable = 1; pwrite = 1; pwdata = 8'h77;
        @(negedge clk);
        chk("t4_pslverr", pslverr, 1);
        @(posedge clk);
        #1;
        tx_en = 0; psel = 0; penable = 0; pwrite = 0;
        chk("t4_fill", fill_level, DEPTH - 1);
        chk("t4_full", full, 0);

        // 5: read access
        @(posedge clk);
        #1;
        psel = 1; penable = 1; pwrite = 0;
        @(negedge clk);
        chk("t5_pslverr", pslverr, 1);
        bus_idle();
        #1;
        chk("t5_fill", fill_level, DEPTH - 1);

        // drain words 0..63 in order
        tx_en = 1; tick_per = 1;
        wait_drain(DEPTH * WIDTH + 200);
        chk("t3_empty", empty, 1);

        // 6: reset mid-word
        tick_per = 2; bits_seen = 0;
        apb_write(8'h3C, 0);
        bus_idle();
        begin
            int n = 0;
            while (bits_seen < 3 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("t6_wait_timeout", int'(n < 200), 1);
        end
        #1;
        reset_n = 0;
        sb.delete();
        #1;
        chk("t6_data_out", data_out, 0);
        chk("t6_busy", tx_busy, 0);
        chk("t6_empty", empty, 1);
        chk("t6_fill", fill_level, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        apb_write(8'h55, 0);
        bus_idle();
        wait_drain(200);

        // Random phase: bounded writes so the FIFO never fills
        tick_per = -1;
        begin
            int nw = 0;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                #1;
                tx_en = ($urandom_range(9) < 7);
                if (nw < 40 && $urandom_range(2) == 0) begin
                    psel = 1; penable = 1; pwrite = 1;
                    pwdata = WIDTH'($urandom);
                    @(negedge clk);
                    chk("rnd_pslverr", pslverr, 0);
                    push_word(pwdata);
                    nw++;
                end else begin
                    psel = 0; penable = 0; pwrite = 0;
                end
            end
        end
        bus_idle();
        tx_en = 1; tick_per = 1;
        wait_drain(1000);
        chk("end_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
